fxp_seq_multiplier: RTL and testbench
=====================================

Name: fxp_seq_multiplier

Overview:
Parametrised, sequential, signed fixed-point multiplier for the neural-network datapath (weight × activation).
- Radix-2 shift-add over WIDTH cycles, replacing the fixed 32-bit combinational array.
- Rescales by FRAC_BITS, saturates on overflow and reports an overflow flag.
- Valid/ready handshakes on both sides so it can sit between a weight/pixel fetch stage and the accumulator.

Parameters:
WIDTH, 32, operand/result width in bits, two's complement; legal range 4..64.
FRAC_BITS, 16, fractional bits of operands and result (Q(WIDTH-FRAC_BITS).FRAC_BITS); legal range 0..WIDTH-1.

Ports:
clk  in  1  rising-edge clock; single clock domain.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand pair a/b is valid.
in_ready  out  1  block can accept operands; high only in IDLE.
a  in  WIDTH  signed multiplicand.
b  in  WIDTH  signed multiplier.
out_valid  out  1  result/overflow are valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  signed, rescaled, saturated product.
overflow  out  1  result was clamped; qualified by out_valid.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, counter=0.
- rst wins over every other event in any state. Mid-operation reset discards the operation; no output is produced for it.
- FSM states: IDLE, CALC, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch |a|, |b| as WIDTH-bit unsigned magnitudes (|−2^(WIDTH−1)| = 2^(WIDTH−1) is representable), sign=a[MSB]^b[MSB].
  - Clear the 2*WIDTH-bit product accumulator and the counter, then go to CALC.
- CALC:
  - One step per cycle: if multiplier LSB=1, add the multiplicand into the upper half of the accumulator (carry kept). Shift accumulator right 1; shift multiplier right 1.
  - Exactly WIDTH cycles, then go to NORM.
- NORM (1 cycle):
  - mag = prod >> FRAC_BITS (see the optional feature for rounding).
  - Positive sign: if mag > 2^(WIDTH−1)−1 then result = max positive and overflow=1.
  - Negative sign: if mag > 2^(WIDTH−1) then result = most negative and overflow=1; otherwise result = −mag.
  - A zero magnitude with negative sign yields 0.
  - Register result and overflow, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; result and overflow are held stable until out_ready.
  - On out_ready: out_valid=0, go to IDLE.
  - No same-cycle accept: in_ready=0 in DONE.
- Latency and throughput:
  - Operands are accepted on edge E0; out_valid rises after edge E(WIDTH+1).
  - Minimum initiation interval is WIDTH+3 cycles with out_ready held high.
- in_valid outside IDLE is ignored; the upstream stage holds it.
- Inputs are sampled only on the accept edge; later changes to a/b have no effect.

Optional Feature:
Macro: FXP_MULT_ROUND_EN.
- Defined, FRAC_BITS>0: add 2^(FRAC_BITS−1) to the magnitude before the shift, i.e. round-half-away-from-zero. Saturation is checked after rounding.
- Undefined: plain truncation of the magnitude, i.e. toward zero.
- Latency is identical in both builds.

Decomposition:
- Shared package fxp_pkg holds:
  - state enum (IDLE/CALC/NORM/DONE);
  - functions for the max/min saturation constants given WIDTH;
  - the default WIDTH/FRAC_BITS used by the network datapath.
- One sub-module: fxp_sat_round, a combinational mag/sign → result/overflow block used in NORM and reused later by the accumulator.

Test Plan:
All scenarios use WIDTH=16, FRAC_BITS=8 (Q8.8).
1. Basic product: a=0x0180 (1.5), b=0x0200 (2.0) -> result=0x0300, overflow=0; out_valid rises after edge E17.
2. Negative operand: a=0xFE80 (−1.5), b=0x0200 -> result=0xFD00, overflow=0. Also a=0x8000 (−128), b=0x0100 (1.0) -> 0x8000, overflow=0.
3. Saturation:
   - a=0x7FFF, b=0x7FFF -> 0x7FFF, overflow=1.
   - a=0x8000, b=0x8000 -> 0x7FFF, overflow=1.
   - a=0x8000, b=0x0200 -> 0x8000, overflow=1.
4. Rounding: a=0x0001, b=0x0080 -> 0x0001 with FXP_MULT_ROUND_EN, 0x0000 without. a=0xFFFF, b=0x0080 -> 0xFFFF with, 0x0000 without.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> result, overflow and out_valid stable, in_ready=0. Release -> IDLE next cycle, in_ready=1.
6. Reset mid-CALC: assert rst at cycle 5 of CALC -> next edge IDLE, out_valid=0, result=0. A new operation then completes correctly with full latency.

Source files
------------

// File: rtl/fxp_pkg.sv
// -----------------------------------------------------------------------------
// fxp_pkg
// Shared definitions for the fixed-point multiplier datapath:
//   - state_t        : sequencer states of fxp_seq_multiplier
//   - DEF_WIDTH      : operand/result width used by the network datapath
//   - DEF_FRAC_BITS  : fractional bits used by the network datapath
//   - sat_max/sat_min: bit patterns of the largest positive and most negative
//                      two's-complement values for a given width (low bits)
// -----------------------------------------------------------------------------
package fxp_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_FRAC_BITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  // 2^(width-1) - 1 : largest positive value, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Only the low 'width' bits are meaningful: a single 1 in the sign position.
  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fxp_sat_round.sv
// -----------------------------------------------------------------------------
// fxp_sat_round
// Combinational sign-magnitude to two's-complement conversion with
// saturation. Shared between the multiplier normalisation step and the
// downstream accumulator.
//
// Parameters:
//   WIDTH : result width (two's complement)
//   MAG_W : width of the unsigned input magnitude (must exceed WIDTH)
// Ports:
//   mag      in  MAG_W  unsigned magnitude, already rescaled/rounded
//   sign     in  1      1 = negative result
//   result   out WIDTH  signed, clamped value
//   overflow out 1      magnitude did not fit and result was clamped
// -----------------------------------------------------------------------------
module fxp_sat_round
  import fxp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAG_W = 2 * DEF_WIDTH
) (
  input  logic [MAG_W-1:0]        mag,
  input  logic                    sign,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow
);

  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(sat_min(WIDTH));
  // Negative side can reach one further than the positive side.
  localparam logic [MAG_W-1:0] POS_LIM = MAG_W'(MAX_POS);
  localparam logic [MAG_W-1:0] NEG_LIM = POS_LIM + MAG_W'(1);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    if (!sign) begin
      if (mag > POS_LIM) begin
        result   = MAX_POS;
        overflow = 1'b1;
      end else begin
        result = mag[WIDTH-1:0];
      end
    end else begin
      if (mag > NEG_LIM) begin
        result   = MIN_NEG;
        overflow = 1'b1;
      end else begin
        // mag == 2^(WIDTH-1) negates onto itself (most negative value);
        // mag == 0 negates to 0, so a negative zero never escapes.
        result = ~mag[WIDTH-1:0] + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/fxp_seq_multiplier.sv
// -----------------------------------------------------------------------------
// fxp_seq_multiplier
// Sequential signed fixed-point multiplier (radix-2 shift-add, one partial
// product per cycle) for the weight x activation path. Operands are
// Q(WIDTH-FRAC_BITS).FRAC_BITS; the product is rescaled back to the same
// format and saturated.
//
// Optional build macro:
//   FXP_MULT_ROUND_EN : round the rescaled magnitude half-away-from-zero
//                       instead of truncating toward zero. Latency unchanged.
//
// Parameters:
//   WIDTH     : operand/result width, 4..64
//   FRAC_BITS : fractional bits, 0..WIDTH-1
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous, active-high reset
//   in_valid  in  1      a/b valid
//   in_ready  out 1      operands accepted (IDLE only)
//   a         in  WIDTH  signed multiplicand
//   b         in  WIDTH  signed multiplier
//   out_valid out 1      result/overflow valid
//   out_ready in  1      consumer accepts result
//   result    out WIDTH  signed, rescaled, saturated product
//   overflow  out 1      result was clamped
//
// Timing: accept on edge E0, WIDTH CALC edges, one NORM edge; out_valid is
// high after edge E(WIDTH+1) and stays high until out_ready.
// -----------------------------------------------------------------------------
module fxp_seq_multiplier
  import fxp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = $clog2(WIDTH);

`ifdef FXP_MULT_ROUND_EN
  // Half an output LSB in product units; zero when FRAC_BITS == 0.
  localparam logic [PROD_W-1:0] RND_BIAS = (PROD_W'(1) << FRAC_BITS) >> 1;
`endif

  state_t state, state_next;

  logic [WIDTH-1:0]        mcand;
  logic [WIDTH-1:0]        mplier;
  logic [PROD_W-1:0]       acc;
  logic                    sign;
  logic [CNT_W-1:0]        counter;

  logic                    calc_last;
  logic [WIDTH:0]          partial;
  logic [PROD_W-1:0]       mag;
  logic signed [WIDTH-1:0] sat_result;
  logic                    sat_ovf;

  // Unsigned magnitude; the most negative input maps to 2^(WIDTH-1), which
  // still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] u;
    u = x;
    return x[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

  // Product magnitude back to Q format. The product of two magnitudes is at
  // most 2^(2*WIDTH-2), so adding the rounding bias cannot wrap.
  function automatic logic [PROD_W-1:0] rescale(input logic [PROD_W-1:0] prod);
`ifdef FXP_MULT_ROUND_EN
    return (prod + RND_BIAS) >> FRAC_BITS;
`else
    return prod >> FRAC_BITS;
`endif
  endfunction

  assign calc_last = (counter == CNT_W'(WIDTH - 1));

  // Upper half plus multiplicand; the extra bit is the carry that is shifted
  // back into the accumulator MSB.
  assign partial = {1'b0, acc[PROD_W-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

  assign mag = rescale(acc);

  fxp_sat_round #(
    .WIDTH (WIDTH),
    .MAG_W (PROD_W)
  ) u_sat_round (
    .mag      (mag),
    .sign     (sign),
    .result   (sat_result),
    .overflow (sat_ovf)
  );

  // ---- sequencer state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (calc_last) state_next = NORM;
      end
      NORM: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---- control / output registers (reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      counter  <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) counter <= '0;
        CALC: counter <= counter + CNT_W'(1);
        NORM: begin
          result   <= sat_result;
          overflow <= sat_ovf;
        end
        default: ;
      endcase
    end
  end

  // ---- shift-add datapath (no reset; always loaded on accept) ----
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          mcand  <= abs_mag(a);
          mplier <= abs_mag(b);
          sign   <= a[WIDTH-1] ^ b[WIDTH-1];
          acc    <= '0;
        end
      end
      CALC: begin
        acc    <= {partial, acc[WIDTH-1:1]};
        mplier <= mplier >> 1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fxp_seq_multiplier.sv
module tb_fxp_seq_multiplier;

  localparam int W = 16;
  localparam int F = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic out_valid;
  logic out_ready;
  logic signed [W-1:0] result;
  logic overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] r;
    logic        o;
  } exp_t;

  exp_t expq[$];

  fxp_seq_multiplier #(.WIDTH(W), .FRAC_BITS(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, rescaled by 2^F, clamped to Q8.8.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t   e;
    longint p;
    longint m;
    p = longint'($signed(x)) * longint'($signed(y));
    m = (p < 0) ? -p : p;
`ifdef FXP_MULT_ROUND_EN
    m = m + 128;
`endif
    m = m / 256;
    if (p < 0) begin
      if (m > 32768) begin e.r = 16'h8000; e.o = 1'b1; end
      else begin e.r = 16'(-m); e.o = 1'b0; end
    end else begin
      if (m > 32767) begin e.r = 16'h7FFF; e.o = 1'b1; end
      else begin e.r = 16'(m); e.o = 1'b0; end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard bookkeeping on handshakes.
  always @(posedge clk) begin
    if (rst) begin
      expq.delete();
    end else begin
      if (in_valid && in_ready) expq.push_back(model(a, b));
      if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
    end
  end

  // Compare every cycle the output is valid.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmp_unexpected: out_valid=1 with result 0x%0h, required no output", result);
      end else begin
        check("cmp_result", result, expq[0].r);
        check("cmp_overflow", {15'd0, overflow}, {15'd0, expq[0].o});
        check("cmp_in_ready", {15'd0, in_ready}, 16'd0);
      end
    end
  end

  task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic eo, input int hold);
    exp_t m;
    int   cyc;
    bit   seen;
    m = model(x, y);
    check({name, "_model_r"}, m.r, er);
    check({name, "_model_o"}, {15'd0, m.o}, {15'd0, eo});
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'h5A5A; b = 16'hA5A5;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check({name, "_latency"}, 16'(cyc), 16'd17);
    check({name, "_result"}, result, er);
    check({name, "_overflow"}, {15'd0, overflow}, {15'd0, eo});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_hold_valid"}, {15'd0, out_valid}, 16'd1);
      check({name, "_hold_result"}, result, er);
      check({name, "_hold_ovf"}, {15'd0, overflow}, {15'd0, eo});
      check({name, "_hold_in_ready"}, {15'd0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_release_valid"}, {15'd0, out_valid}, 16'd0);
    check({name, "_release_in_ready"}, {15'd0, in_ready}, 16'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r_small;
    logic [15:0] r_negsmall;
`ifdef FXP_MULT_ROUND_EN
    r_small    = 16'h0001;
    r_negsmall = 16'hFFFF;
`else
    r_small    = 16'h0000;
    r_negsmall = 16'h0000;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {15'd0, in_ready}, 16'd1);
    check("reset_out_valid", {15'd0, out_valid}, 16'd0);
    check("reset_result", result, 16'h0000);
    check("reset_overflow", {15'd0, overflow}, 16'd0);
    rst = 1'b0;

    run_op("basic",      16'h0180, 16'h0200, 16'h0300, 1'b0, 0);
    run_op("neg",        16'hFE80, 16'h0200, 16'hFD00, 1'b0, 0);
    run_op("minus128",   16'h8000, 16'h0100, 16'h8000, 1'b0, 0);
    run_op("sat_maxmax", 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 0);
    run_op("sat_minmin", 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 0);
    run_op("sat_neg",    16'h8000, 16'h0200, 16'h8000, 1'b1, 0);

    // Reset during CALC: accept on E0, rst sampled on E5.
    @(negedge clk);
    a = 16'h0300; b = 16'h0200; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_result", result, 16'h0000);
    check("midrst_overflow", {15'd0, overflow}, 16'd0);
    rst = 1'b0;

    run_op("after_rst",  16'h0300, 16'h0200, 16'h0600, 1'b0, 0);
    run_op("round_pos",  16'h0001, 16'h0080, r_small, 1'b0, 0);
    run_op("round_neg",  16'hFFFF, 16'h0080, r_negsmall, 1'b0, 0);
    run_op("neg_zero",   16'h0000, 16'hFF00, 16'h0000, 1'b0, 0);
    run_op("backpress",  16'h0180, 16'h0200, 16'h0300, 1'b0, 10);
    run_op("neg_neg",    16'hFE00, 16'hFD00, 16'h0600, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
